frontend_pipe_regs: RTL and testbench

- Sequential counterpart to the hazard unit: holds PCF, the IF/ID register and the ID/EX register, and consumes StallF, StallD, FlushD, FlushE and PcSrc.
- Sits between instruction memory/decode and execute in the 5-stage pipeline.
- Produces the E-stage fields the hazard unit reads back: Rs1E, Rs2E, RdE and CtrlE, where CtrlE[2:1] is ResultSrcE.
- Keeps saturating stall and redirect event counters for performance debug.

---
 rtl/frontend_pipe_regs.sv | 136 +++++++++++++
 tb/tb_frontend_pipe_regs.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/frontend_pipe_regs.sv
// Fetch PC, IF/ID and ID/EX pipeline registers driven by hazard-unit stall/flush/redirect, plus perf counters.
// One edge per stage; no outputs depend combinationally on inputs, and stalls hold state in place.
module frontend_pipe_regs #(
  parameter int               XLEN      = 32,
  parameter logic [XLEN-1:0]  RESET_PC  = '0,
  parameter logic [31:0]      NOP_INSTR = 32'h0000_0013,
  parameter int               CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             StallF,
  input  logic             StallD,
  input  logic             FlushD,
  input  logic             FlushE,
  input  logic             PcSrc,
  input  logic [XLEN-1:0]  PCTargetE,
  input  logic [31:0]      InstrF,
  output logic [XLEN-1:0]  PCF,
  output logic [31:0]      InstrD,
  output logic [XLEN-1:0]  PCD,
  output logic [XLEN-1:0]  PCPlus4D,
  output logic             ValidD,
  input  logic [9:0]       CtrlD,
  input  logic [XLEN-1:0]  RD1D,
  input  logic [XLEN-1:0]  RD2D,
  input  logic [XLEN-1:0]  ImmExtD,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       RdD,
  output logic [9:0]       CtrlE,
  output logic [XLEN-1:0]  RD1E,
  output logic [XLEN-1:0]  RD2E,
  output logic [XLEN-1:0]  ImmExtE,
  output logic [XLEN-1:0]  PCE,
  output logic [XLEN-1:0]  PCPlus4E,
  output logic [4:0]       Rs1E,
  output logic [4:0]       Rs2E,
  output logic [4:0]       RdE,
  output logic             ValidE,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] RedirCount
);

  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pcPlus4;
    logic            valid;
  } ifIdT;

  typedef struct packed {
    logic [9:0]      ctrl;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] immExt;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pcPlus4;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            valid;
  } idExT;

  localparam logic [XLEN-1:0]  PC_STEP = XLEN'(4);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam ifIdT             IFID_BUBBLE = '{instr: NOP_INSTR, pc: '0, pcPlus4: '0, valid: 1'b0};

  logic [XLEN-1:0] pcReg;
  logic [XLEN-1:0] pcPlus4F;
  ifIdT            ifIdReg;
  idExT            idExReg;

  assign pcPlus4F = pcReg + PC_STEP;

  // A redirect must win over a fetch stall, otherwise a taken branch during a stall would be lost.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pcReg <= RESET_PC;
    end else if (PcSrc) begin
      pcReg <= PCTargetE;
    end else if (!StallF) begin
      pcReg <= pcPlus4F;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ifIdReg <= IFID_BUBBLE;
    end else if (FlushD) begin
      ifIdReg <= IFID_BUBBLE;
    end else if (!StallD) begin
      ifIdReg <= '{instr: InstrF, pc: pcReg, pcPlus4: pcPlus4F, valid: 1'b1};
    end
  end

  // All-zero bubble keeps RdE=0 so it can never match a forwarding compare.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idExReg <= '0;
    end else if (FlushE) begin
      idExReg <= '0;
    end else begin
      idExReg <= '{ctrl: CtrlD, rd1: RD1D, rd2: RD2D, immExt: ImmExtD,
                   pc: ifIdReg.pc, pcPlus4: ifIdReg.pcPlus4,
                   rs1: Rs1D, rs2: Rs2D, rd: RdD, valid: ifIdReg.valid};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      StallCount <= '0;
      RedirCount <= '0;
    end else begin
      if (StallD && StallCount != CNT_MAX) StallCount <= StallCount + CNT_W'(1);
      if (PcSrc && RedirCount != CNT_MAX) RedirCount <= RedirCount + CNT_W'(1);
    end
  end

  assign PCF      = pcReg;
  assign InstrD   = ifIdReg.instr;
  assign PCD      = ifIdReg.pc;
  assign PCPlus4D = ifIdReg.pcPlus4;
  assign ValidD   = ifIdReg.valid;

  assign CtrlE    = idExReg.ctrl;
  assign RD1E     = idExReg.rd1;
  assign RD2E     = idExReg.rd2;
  assign ImmExtE  = idExReg.immExt;
  assign PCE      = idExReg.pc;
  assign PCPlus4E = idExReg.pcPlus4;
  assign Rs1E     = idExReg.rs1;
  assign Rs2E     = idExReg.rs2;
  assign RdE      = idExReg.rd;
  assign ValidE   = idExReg.valid;

endmodule

// File: tb/tb_frontend_pipe_regs.sv
// Bench for frontend_pipe_regs: stimulus pushes expected post-edge state, a monitor pops and compares after each edge.
module tb_frontend_pipe_regs;

  localparam int NF = 11;
  localparam int F_PCF = 0, F_INSTRD = 1, F_PCD = 2, F_VALIDD = 3, F_CTRLE = 4, F_RDE = 5,
                 F_VALIDE = 6, F_STALLC = 7, F_REDIRC = 8, F_PCE = 9, F_PCP4D = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic        StallF, StallD, FlushD, FlushE, PcSrc;
  logic [31:0] PCTargetE, InstrF;
  logic [31:0] PCF, InstrD, PCD, PCPlus4D;
  logic        ValidD;
  logic [9:0]  CtrlD, CtrlE;
  logic [31:0] RD1D, RD2D, ImmExtD, RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
  logic [4:0]  Rs1D, Rs2D, RdD, Rs1E, Rs2E, RdE;
  logic        ValidE;
  logic [15:0] StallCount, RedirCount;

  frontend_pipe_regs dut (
    .clk(clk), .rst(rst),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE), .PcSrc(PcSrc),
    .PCTargetE(PCTargetE), .InstrF(InstrF),
    .PCF(PCF), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD),
    .CtrlD(CtrlD), .RD1D(RD1D), .RD2D(RD2D), .ImmExtD(ImmExtD),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
    .CtrlE(CtrlE), .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .PCE(PCE), .PCPlus4E(PCPlus4E),
    .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .ValidE(ValidE),
    .StallCount(StallCount), .RedirCount(RedirCount)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NF-1:0]       en;
    logic [NF-1:0][31:0] val;
  } expT;

  expT   sb[$];
  expT   pend;
  int    errors = 0;
  int    checks = 0;
  string fname[NF] = '{"PCF", "InstrD", "PCD", "ValidD", "CtrlE", "RdE", "ValidE",
                       "StallCount", "RedirCount", "PCE", "PCPlus4D"};
  logic [31:0] rstVal[NF] = '{32'h0, 32'h13, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                              32'h0, 32'h0, 32'h0, 32'h0};

  function automatic logic [31:0] actual(int f);
    case (f)
      F_PCF:    return PCF;
      F_INSTRD: return InstrD;
      F_PCD:    return PCD;
      F_VALIDD: return {31'b0, ValidD};
      F_CTRLE:  return {22'b0, CtrlE};
      F_RDE:    return {27'b0, RdE};
      F_VALIDE: return {31'b0, ValidE};
      F_STALLC: return {16'b0, StallCount};
      F_REDIRC: return {16'b0, RedirCount};
      F_PCE:    return PCE;
      default:  return PCPlus4D;
    endcase
  endfunction

  task automatic check(input string n, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", n, act, req);
    end
  endtask

  task automatic want(input int f, input logic [31:0] v);
    pend.en[f]  = 1'b1;
    pend.val[f] = v;
  endtask

  task automatic commit();
    sb.push_back(pend);
    pend = '0;
  endtask

  task automatic drive(input logic sF, input logic sD, input logic fD, input logic fE,
                       input logic pc, input logic [31:0] tgt, input logic [31:0] instr);
    StallF = sF; StallD = sD; FlushD = fD; FlushE = fE; PcSrc = pc;
    PCTargetE = tgt; InstrF = instr;
  endtask

  task automatic checkResetState(input string tag);
    for (int f = 0; f < NF; f++) check({tag, ".", fname[f]}, actual(f), rstVal[f]);
  endtask

  // Monitor: consume one expectation per edge, sampled 1 time unit after the edge.
  initial begin
    expT e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        for (int f = 0; f < NF; f++)
          if (e.en[f]) check(fname[f], actual(f), e.val[f]);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    pend = '0;
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 32'h0, 32'h00500093);
    CtrlD = 10'h155; RD1D = 32'h1111_1111; RD2D = 32'h2222_2222; ImmExtD = 32'h5;
    Rs1D = 5'd1; Rs2D = 5'd2; RdD = 5'd7;

    repeat (2) @(posedge clk);
    #1;
    checkResetState("reset");

    // Release; first edge fetches RESET_PC.
    @(negedge clk); rst = 1'b1;
    want(F_PCF, 32'h4); want(F_INSTRD, 32'h00500093); want(F_PCD, 32'h0); want(F_PCP4D, 32'h4);
    want(F_VALIDD, 1); want(F_CTRLE, 32'h155); want(F_RDE, 7); want(F_VALIDE, 0); commit();
    @(negedge clk);
    want(F_PCF, 32'h8); want(F_PCD, 32'h4); want(F_VALIDE, 1); want(F_PCE, 32'h0); commit();
    @(negedge clk);
    want(F_PCF, 32'hC); want(F_PCD, 32'h8); want(F_PCE, 32'h4); commit();
    @(negedge clk); drive(0, 0, 0, 0, 0, 32'h0, 32'h00A00113);
    want(F_PCF, 32'h10); want(F_INSTRD, 32'h00A00113); want(F_PCD, 32'hC); want(F_PCE, 32'h8); commit();

    // Load-use: hold F and D, bubble into E.
    @(negedge clk); drive(1, 1, 0, 1, 0, 32'h0, 32'hDEADBEEF);
    want(F_PCF, 32'h10); want(F_INSTRD, 32'h00A00113); want(F_PCD, 32'hC); want(F_VALIDD, 1);
    want(F_CTRLE, 0); want(F_RDE, 0); want(F_VALIDE, 0); want(F_PCE, 0); want(F_STALLC, 1); commit();
    @(negedge clk); drive(0, 0, 0, 0, 0, 32'h0, 32'h00300193);
    want(F_PCF, 32'h14); want(F_INSTRD, 32'h00300193); want(F_PCD, 32'h10);
    want(F_PCE, 32'hC); want(F_CTRLE, 32'h155); want(F_RDE, 7); want(F_VALIDE, 1); want(F_STALLC, 1); commit();

    // Taken branch.
    @(negedge clk); drive(0, 0, 1, 1, 1, 32'h100, 32'h00400213);
    want(F_PCF, 32'h100); want(F_INSTRD, 32'h13); want(F_PCD, 0); want(F_PCP4D, 0); want(F_VALIDD, 0);
    want(F_CTRLE, 0); want(F_RDE, 0); want(F_VALIDE, 0); want(F_REDIRC, 1); commit();

    // Priority: redirect over StallF, flush over StallD.
    @(negedge clk); drive(1, 1, 1, 0, 1, 32'h200, 32'h00400213);
    want(F_PCF, 32'h200); want(F_INSTRD, 32'h13); want(F_VALIDD, 0); want(F_REDIRC, 2);
    want(F_STALLC, 2); want(F_VALIDE, 0); want(F_CTRLE, 32'h155); want(F_PCE, 0); commit();

    // PC wrap at the top of the address space.
    @(negedge clk); drive(0, 0, 0, 0, 1, 32'hFFFF_FFFC, 32'h00500293);
    want(F_PCF, 32'hFFFF_FFFC); want(F_INSTRD, 32'h00500293); want(F_PCD, 32'h200);
    want(F_PCP4D, 32'h204); want(F_VALIDD, 1); want(F_REDIRC, 3); commit();
    @(negedge clk); drive(0, 0, 0, 0, 0, 32'h0, 32'h00600313);
    want(F_PCF, 32'h0); want(F_PCD, 32'hFFFF_FFFC); want(F_PCP4D, 32'h0);
    want(F_VALIDE, 1); want(F_PCE, 32'h200); want(F_REDIRC, 3); commit();

    // Asynchronous reset between edges.
    @(negedge clk); rst = 1'b0;
    #1;
    checkResetState("midrst");
    @(negedge clk); rst = 1'b1;
    want(F_PCF, 32'h4); want(F_PCD, 32'h0); want(F_VALIDD, 1); want(F_STALLC, 0); want(F_REDIRC, 0); commit();

    // StallCount saturation.
    for (int k = 1; k <= 70000; k++) begin
      @(negedge clk);
      StallD = 1'b1;
      if (k == 65534) begin want(F_STALLC, 32'hFFFE); commit(); end
      if (k == 65535) begin want(F_STALLC, 32'hFFFF); commit(); end
      if (k == 70000) begin want(F_STALLC, 32'hFFFF); commit(); end
    end
    @(negedge clk); StallD = 1'b0;

    repeat (3) @(negedge clk);
    check("scoreboard_drain", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
